// File: rtl/accum_burst_ctrl.sv
// Burst sequencer for the 8-bit accumulator stage: clears it, streams LEN samples
// over valid/ready, then captures the final sum and a sticky overflow flag.
module accum_burst_ctrl #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned LEN_W  = 8
) (
  input  logic              clock,
  input  logic              clear,
  input  logic              start,
  input  logic [LEN_W-1:0]  len,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic [DATA_W-1:0] in1,
  output logic              acc,
  output logic              acc_clr,
  input  logic [DATA_W-1:0] acc_out,
  input  logic              overflow,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result,
  output logic              ovf_flag
);

  typedef enum logic [2:0] {IDLE, CLR, RUN, SETTLE, DONE} state_t;

  state_t           state;
  logic [LEN_W-1:0] remaining;
  logic             ovf_sticky;

  // Handshake and accumulator controls decode directly from the state.
  assign s_ready = (state == RUN);
  assign acc     = s_valid & s_ready;
  assign in1     = s_ready ? s_data : '0;
  assign busy    = (state != IDLE);
  assign acc_clr = clear | (state == CLR);

  // Wrap flag is gathered privately and published with the sum, so the
  // visible result/ovf_flag pair only moves on completion or reset.
  always_ff @(posedge clock) begin
    if (clear) begin
      state      <= IDLE;
      remaining  <= '0;
      ovf_sticky <= 1'b0;
      result     <= '0;
      ovf_flag   <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (len != '0) begin
              remaining <= len;
              state     <= CLR;
            end else begin
              result   <= '0;
              ovf_flag <= 1'b0;
              done     <= 1'b1;
              state    <= DONE;
            end
          end
        end
        CLR: begin
          ovf_sticky <= 1'b0;
          state      <= RUN;
        end
        RUN: begin
          if (acc) begin
            remaining  <= remaining - LEN_W'(1);
            ovf_sticky <= ovf_sticky | overflow;
            if (remaining == LEN_W'(1)) state <= SETTLE;
          end
        end
        SETTLE: begin
          result   <= acc_out;
          ovf_flag <= ovf_sticky;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_accum_burst_ctrl.sv
// Directed bench for accum_burst_ctrl with a behavioural 8-bit accumulator
// attached to its in1/acc/acc_clr -> acc_out/overflow interface.
module tb_accum_burst_ctrl;

  localparam int unsigned DATA_W = 8;
  localparam int unsigned LEN_W  = 8;

  logic              clock = 1'b0;
  logic              clear;
  logic              start;
  logic [LEN_W-1:0]  len;
  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] in1;
  logic              acc;
  logic              acc_clr;
  logic [DATA_W-1:0] acc_out;
  logic              overflow;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] result;
  logic              ovf_flag;

  int n_checks = 0;
  int n_fail   = 0;
  logic [DATA_W-1:0] vec [8];

  accum_burst_ctrl #(.DATA_W(DATA_W), .LEN_W(LEN_W)) dut (
    .clock(clock), .clear(clear), .start(start), .len(len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .in1(in1), .acc(acc), .acc_clr(acc_clr), .acc_out(acc_out),
    .overflow(overflow), .busy(busy), .done(done),
    .result(result), .ovf_flag(ovf_flag)
  );

  always #5 clock = ~clock;

  // Accumulator stage model: registered sum, combinational carry-out.
  logic [DATA_W:0] sum_w;
  assign sum_w    = {1'b0, acc_out} + {1'b0, in1};
  assign overflow = sum_w[DATA_W];
  always @(posedge clock) begin
    if (acc_clr)  acc_out <= '0;
    else if (acc) acc_out <= sum_w[DATA_W-1:0];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  // Runs one burst from vec[]; gap = idle cycles after each beat; poke = hammer start with len 9.
  task automatic burst(input int n, input int gap, input bit poke, input logic [31:0] prev_res,
                       output int done_cyc, output int beats, output int clr_cnt, output int rdy_cnt);
    int cyc = 1;
    int idx = 0;
    int gapcnt = 0;
    done_cyc = -1; beats = 0; clr_cnt = 0; rdy_cnt = 0;
    start = 1'b1; len = LEN_W'(n); s_valid = 1'b0;
    cycle();
    while (cyc < 100) begin
      if (done) begin
        done_cyc = cyc;
        break;
      end
      chk("result_hold", 32'(result), prev_res);
      start   = poke;
      len     = poke ? LEN_W'(9) : LEN_W'(n);
      s_valid = (idx < n) && (gapcnt == 0);
      s_data  = (idx < n) ? vec[idx] : DATA_W'(8'hEE);
      #1;
      if (acc_clr) clr_cnt++;
      if (s_ready) rdy_cnt++;
      if (acc) begin
        chk("in1_beat", 32'(in1), 32'(vec[idx]));
        idx++; beats++; gapcnt = gap;
      end else begin
        if (!s_ready) chk("in1_zero", 32'(in1), 32'd0);
        if (s_ready && gapcnt > 0) gapcnt--;
      end
      cycle();
      cyc++;
    end
    start = 1'b0; s_valid = 1'b0;
    if (done_cyc < 0) chk("done_timeout", 32'd0, 32'd1);
    chk("ready_in_done", 32'(s_ready), 32'd0);
    chk("clr_in_done", 32'(acc_clr), 32'd0);
  endtask

  int dc, bt, cc, rc;

  initial begin
    clear = 1'b1; start = 1'b0; len = '0; s_data = '0; s_valid = 1'b0;
    #1;
    chk("rst_acc_clr", 32'(acc_clr), 32'd1);
    cycle(); cycle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_result", 32'(result), 32'd0);
    chk("rst_ovf", 32'(ovf_flag), 32'd0);
    chk("rst_ready", 32'(s_ready), 32'd0);
    clear = 1'b0;
    cycle();

    // Four back-to-back beats.
    vec[0] = 8'd1; vec[1] = 8'd2; vec[2] = 8'd3; vec[3] = 8'd4;
    burst(4, 0, 1'b0, 32'd0, dc, bt, cc, rc);
    chk("t1_done_cyc", 32'(dc), 32'd7);
    chk("t1_result", 32'(result), 32'd10);
    chk("t1_ovf", 32'(ovf_flag), 32'd0);
    chk("t1_beats", 32'(bt), 32'd4);
    chk("t1_clr_cnt", 32'(cc), 32'd1);
    cycle();
    chk("t1_done_pulse", 32'(done), 32'd0);
    chk("t1_idle", 32'(busy), 32'd0);

    // Wrapping burst: 200+100 = 300 -> 44 with overflow.
    vec[0] = 8'd200; vec[1] = 8'd100;
    burst(2, 0, 1'b0, 32'd10, dc, bt, cc, rc);
    chk("t2a_done_cyc", 32'(dc), 32'd5);
    chk("t2a_result", 32'(result), 32'd44);
    chk("t2a_ovf", 32'(ovf_flag), 32'd1);
    cycle();

    // Zero-length request completes immediately and clears the flags.
    burst(0, 0, 1'b0, 32'd44, dc, bt, cc, rc);
    chk("t4_done_cyc", 32'(dc), 32'd1);
    chk("t4_result", 32'(result), 32'd0);
    chk("t4_ovf", 32'(ovf_flag), 32'd0);
    chk("t4_ready_cnt", 32'(rc), 32'd0);
    chk("t4_clr_cnt", 32'(cc), 32'd0);
    cycle();

    // Single beat after an overflowing burst.
    vec[0] = 8'd5;
    burst(1, 0, 1'b0, 32'd0, dc, bt, cc, rc);
    chk("t2b_done_cyc", 32'(dc), 32'd4);
    chk("t2b_result", 32'(result), 32'd5);
    chk("t2b_ovf", 32'(ovf_flag), 32'd0);
    cycle();

    // Two stall cycles after each beat.
    vec[0] = 8'd10; vec[1] = 8'd20; vec[2] = 8'd30;
    burst(3, 2, 1'b0, 32'd5, dc, bt, cc, rc);
    chk("t3_done_cyc", 32'(dc), 32'd10);
    chk("t3_result", 32'(result), 32'd60);
    chk("t3_beats", 32'(bt), 32'd3);
    chk("t3_ready_cnt", 32'(rc), 32'd7);
    cycle();

    // Reset in the middle of a five-beat burst, after two accepted beats.
    start = 1'b1; len = LEN_W'(5); s_valid = 1'b1; s_data = 8'd1;
    cycle();
    start = 1'b0;
    cycle();
    s_data = 8'd2;
    cycle();
    s_data = 8'd3;
    cycle();
    chk("t5_in_run", 32'(s_ready), 32'd1);
    s_valid = 1'b0; clear = 1'b1;
    #1;
    chk("t5_acc_clr", 32'(acc_clr), 32'd1);
    cycle();
    clear = 1'b0;
    #1;
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_result", 32'(result), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_ready", 32'(s_ready), 32'd0);
    cycle();
    vec[0] = 8'd7;
    burst(1, 0, 1'b0, 32'd0, dc, bt, cc, rc);
    chk("t5_new_done_cyc", 32'(dc), 32'd4);
    chk("t5_new_result", 32'(result), 32'd7);
    cycle();

    // start with another len while busy must be ignored.
    vec[0] = 8'd50; vec[1] = 8'd60; vec[2] = 8'd70;
    burst(3, 0, 1'b1, 32'd7, dc, bt, cc, rc);
    chk("t6_done_cyc", 32'(dc), 32'd6);
    chk("t6_result", 32'(result), 32'd180);
    chk("t6_beats", 32'(bt), 32'd3);
    chk("t6_clr_cnt", 32'(cc), 32'd1);
    cycle();
    chk("t6_idle", 32'(busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
